i2c_target: RTL and testbench
=============================

# i2c_target

I2C responder (target) for the fabric I2C bus, the bus-side counterpart of the I2C control unit's initiator. It decodes START/STOP conditions, acknowledges its 7-bit address and exposes a byte-wide register-access port to local logic. Supported transfers are register-address-plus-data writes with auto-increment, and register reads (random read via repeated START, or sequential read). It sits between the open-drain pad logic and a local register file.

## Interface

Parameters:
- `SLAVE_ADDRESS`, default `7'h50`: 7-bit address this target acknowledges.
- `FILTER_DEPTH`, default `3`: clock cycles a synchronized line level must be stable before it is accepted (range 1–15).

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high.
- `scl_in`, in, 1: raw SCL pad level.
- `sda_in`, in, 1: raw SDA pad level.
- `sda_out_en`, out, 1: 1 = pull SDA low. The pad is open-drain; this block never drives SDA high.
- `reg_addr`, out, 8: current register pointer.
- `wr_data`, out, 8: received data byte.
- `wr_valid`, out, 1: one-cycle strobe; `reg_addr`/`wr_data` are valid with it.
- `rd_req`, out, 1: one-cycle strobe requesting the byte at `reg_addr`.
- `rd_data`, in, 8: read data, sampled exactly 1 cycle after `rd_req`.
- `busy`, out, 1: high from an address match until STOP.

## Operation

- **Input conditioning.**
  - `scl_in` and `sda_in` each pass through a 2-FF synchronizer and then the stability filter.
  - Edge and condition detection operate on the filtered levels only.
  - START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high.
- **Bit timing.**
  - Data bits are sampled on filtered SCL rising edges.
  - `sda_out_en` changes only on filtered SCL falling edges, or on STOP/START/reset.
- **States:** IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **IDLE → ADDR** on START. The bit counter clears.
- **ADDR:** shift in 8 bits, MSB first. On the 8th bit:
  - If `addr[7:1] == SLAVE_ADDRESS`: go to ADDR_ACK, set `busy`, and drive ACK (SDA low) from the next SCL fall through the following fall.
  - Otherwise (including general call 0x00): go to IGNORE and leave SDA released.
- **ADDR_ACK exit:**
  - R/W = 0 → REG.
  - R/W = 1 → pulse `rd_req`, load `rd_data` into the TX shifter, go to RDATA.
- **REG:** 8 bits are loaded into `reg_addr`, then ACK → WDATA.
- **WDATA:** after 8 bits:
  - Pulse `wr_valid` on the cycle the 8th bit is sampled.
  - ACK through WDATA_ACK.
  - Increment `reg_addr` on the ACK-ending SCL fall, then return to WDATA.
- **RDATA:** MSB is presented on the SDA line at the SCL fall that ends ADDR_ACK (or RDATA_ACK). One bit is shifted per SCL fall (bit = 0 → `sda_out_en` = 1). After 8 bits, SDA is released → RDATA_ACK.
- **RDATA_ACK:** sample the master's bit on the SCL rise.
  - ACK (0): increment `reg_addr` and pulse `rd_req` on the SCL fall, then RDATA.
  - NACK (1): IGNORE.
- **IGNORE:** SDA released; waits for START (→ ADDR) or STOP (→ IDLE).
- **STOP** in any state → IDLE, `busy` = 0, SDA released the next cycle.
- **START** in any state (repeated START) → ADDR. `reg_addr` is retained, so write-register-then-read works.
- **Partial byte:** if a byte is aborted by START/STOP, it produces no `wr_valid` or `reg_addr` update.
- **Wrap-around:** `reg_addr` wraps 0xFF → 0x00.

## Timing

- Reset values: all outputs 0, `reg_addr` = 0, state IDLE, filters preset to level 1 (bus idle).
- Pad-to-internal latency: 2 + `FILTER_DEPTH` cycles. The `clock` frequency must be at least 16× SCL.
- `sda_out_en` update: 1 cycle after the detected filtered SCL fall.
- `wr_valid`: 1 cycle after the 8th-bit SCL rise is detected.
- `rd_req` → `rd_data` sample: exactly 1 cycle.
- START and SCL fall detected in the same cycle: START wins.
- `reset` mid-transfer: `sda_out_en` = 0 in the cycle after `reset` is sampled high.

## Structure

- Package `i2c_pkg` holds:
  - the state enum `i2c_target_state_t`;
  - constants `I2C_ACK` = 0 and `I2C_NACK` = 1;
  - `I2C_BYTE_BITS` = 8.
- Sub-module `i2c_line_conditioner` contains the synchronizer, stability filter and rise/fall detect. It has one instance per line (SCL, SDA). START/STOP decode stays in `i2c_target`.

## Test plan

- **Write, 2 bytes:** START, 0xA0, reg 0x10, data 0x5A, 0xC3, STOP → two `wr_valid` pulses: (0x10, 0x5A) and (0x11, 0xC3); ACK on all 4 bytes; `busy` falls after STOP.
- **Random read:** START 0xA0, reg 0xFE, repeated START, 0xA1, master ACK then NACK, rd_data model returns `addr ^ 0xFF` → SDA carries 0x01 then 0x00; `rd_req` asserted for 0xFE, then 0xFF.
- **Wrong address:** 0xA2 write → no ACK, `sda_out_en` never asserted, no strobes, `busy` stays 0.
- **Wrap and abort:** write from reg 0xFF with 2 bytes → second write lands at 0x00. Then STOP after 5 bits of a 3rd byte → no further `wr_valid`.
- **Glitch and reset:** a 1-cycle SCL glitch during WDATA → ignored, byte still correct. Asserting `reset` while driving ACK → `sda_out_en` low the next cycle, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_target_state_t;

  localparam logic I2C_ACK       = 1'b0;
  localparam logic I2C_NACK      = 1'b1;
  localparam int   I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_line_conditioner.sv
// One bus line: 2-FF synchronizer, stability filter and edge pulses on the filtered level.
// rise_o/fall_o are high in the same cycle the new filtered level first appears on level_o.
module i2c_line_conditioner #(
  parameter int FILTER_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_DEPTH - 1);

  logic [1:0] sync_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;
  logic [3:0] cnt_q;

  // Level is preset high so an idle bus produces no edges out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, register-pointer write with auto-increment, sequential/random read.
//   state        | meaning
//   ST_IDLE      | bus free, waiting for START
//   ST_ADDR      | shifting in address + R/W
//   ST_ADDR_ACK  | driving ACK for our address
//   ST_REG       | shifting in register pointer
//   ST_REG_ACK   | driving ACK for register pointer
//   ST_WDATA     | shifting in a write data byte
//   ST_WDATA_ACK | driving ACK for write data, pointer advances at its end
//   ST_RDATA     | shifting out a read data byte
//   ST_RDATA_ACK | sampling the initiator's ACK/NACK
//   ST_IGNORE    | not addressed or read ended, waiting for START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
  parameter int         FILTER_DEPTH  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out_en,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [3:0] BIT_LAST = 4'(I2C_BYTE_BITS - 1);
  localparam logic [3:0] BIT_ALL  = 4'(I2C_BYTE_BITS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_conditioner #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl (
    .clock  (clock),
    .reset  (reset),
    .line_i (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_conditioner #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda (
    .clock  (clock),
    .reset  (reset),
    .line_i (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_target_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wvalid_q, wvalid_d;
  logic       rdreq_q, rdreq_d;
  logic       rdpend_q;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       ackdrv_q, ackdrv_d;
  logic       rw_q, rw_d;
  logic       ackbit_q, ackbit_d;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      rdreq_q  <= 1'b0;
      rdpend_q <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      ackdrv_q <= 1'b0;
      rw_q     <= 1'b0;
      ackbit_q <= I2C_NACK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      rdreq_q  <= rdreq_d;
      rdpend_q <= rdreq_q;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      ackdrv_q <= ackdrv_d;
      rw_q     <= rw_d;
      ackbit_q <= ackbit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    rdreq_d  = 1'b0;
    oe_d     = oe_q;
    busy_d   = busy_q;
    ackdrv_d = ackdrv_q;
    rw_d     = rw_q;
    ackbit_d = ackbit_q;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      oe_d     = 1'b0;
      ackdrv_d = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      oe_d     = 1'b0;
      ackdrv_d = 1'b0;
    end else begin
      // Read data returns one cycle after rd_req; its MSB goes onto the bus as soon as it lands.
      if (rdpend_q && state_q == ST_RDATA) begin
        tx_d = rd_data;
        oe_d = ~rd_data[7];
      end
      unique case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == BIT_LAST) begin
              cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDRESS) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_REG) begin
                addr_d  = rx_byte;
                state_d = ST_REG_ACK;
              end else begin
                wdata_d  = rx_byte;
                wvalid_d = 1'b1;
                state_d  = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          // First fall starts the ACK bit, second fall ends it.
          if (scl_fall) begin
            if (!ackdrv_q) begin
              oe_d     = 1'b1;
              ackdrv_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              ackdrv_d = 1'b0;
              cnt_d    = '0;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  rdreq_d = 1'b1;
                  state_d = ST_RDATA;
                end else begin
                  state_d = ST_REG;
                end
              end else if (state_q == ST_REG_ACK) begin
                state_d = ST_WDATA;
              end else begin
                addr_d  = addr_q + 8'd1;
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == BIT_ALL) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = ST_RDATA_ACK;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ackbit_d = sda_lvl;
          end else if (scl_fall) begin
            if (ackbit_q == I2C_ACK) begin
              addr_d  = addr_q + 8'd1;
              rdreq_d = 1'b1;
              cnt_d   = '0;
              state_d = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_out_en = oe_q;
  assign reg_addr   = addr_q;
  assign wr_data    = wdata_q;
  assign wr_valid   = wvalid_q;
  assign rd_req     = rdreq_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bit-banged initiator drives the bus, a monitor checks strobes.
module tb_i2c_target;

  localparam int Q = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       glitch = 1'b0;
  logic       glitch_on = 1'b0;
  logic       scl_in, sda_in, sda_out_en;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_valid, rd_req, busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic        watch = 1'b0;
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;

  assign scl_in  = scl_m ^ glitch;
  assign sda_in  = sda_m & ~sda_out_en;
  assign rd_data = reg_addr ^ 8'hFF;

  i2c_target #(.SLAVE_ADDRESS(7'h50), .FILTER_DEPTH(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_out_en(sda_out_en),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_valid) begin
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, expected no strobe", reg_addr, wr_data);
        end else begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(e[15:8]));
          check("wr_data", 32'(wr_data), 32'(e[7:0]));
        end
      end
      if (rd_req) begin
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got addr %0h, expected no strobe", reg_addr);
        end else begin
          logic [7:0] a;
          a = exp_rd.pop_front();
          check("rd_addr", 32'(reg_addr), 32'(a));
        end
      end
      if (watch && sda_out_en) oe_seen = 1'b1;
      if (watch && busy) busy_seen = 1'b1;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b1; clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;
    if (glitch_on) begin
      clks(4);
      glitch = 1'b1; clks(1);
      glitch = 1'b0; clks(Q - 5);
    end else begin
      clks(Q);
    end
    scl_m = 1'b1; clks(2 * Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    b = sda_in;   clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_in, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] wa;

    clks(5);
    check("rst_sda_out_en", 32'(sda_out_en), 32'h0);
    check("rst_reg_addr", 32'(reg_addr), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_rd_req", 32'(rd_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    clks(10);

    // Two-byte write from register 0x10.
    i2c_start();
    write_byte(8'hA0, ack); check("w_addr_ack", 32'(ack), 32'h0);
    check("w_busy", 32'(busy), 32'h1);
    write_byte(8'h10, ack); check("w_reg_ack", 32'(ack), 32'h0);
    exp_wr.push_back(16'h105A);
    write_byte(8'h5A, ack); check("w_d0_ack", 32'(ack), 32'h0);
    exp_wr.push_back(16'h11C3);
    write_byte(8'hC3, ack); check("w_d1_ack", 32'(ack), 32'h0);
    i2c_stop();
    clks(10);
    check("w_busy_after_stop", 32'(busy), 32'h0);
    check("w_reg_addr_final", 32'(reg_addr), 32'h12);

    // Random read: pointer 0xFE, repeated START, two bytes.
    i2c_start();
    write_byte(8'hA0, ack); check("r_addr_ack", 32'(ack), 32'h0);
    write_byte(8'hFE, ack); check("r_reg_ack", 32'(ack), 32'h0);
    exp_rd.push_back(8'hFE);
    exp_rd.push_back(8'hFF);
    i2c_start();
    write_byte(8'hA1, ack); check("r_addr_rd_ack", 32'(ack), 32'h0);
    read_byte(1'b0, d); check("r_data0", 32'(d), 32'h01);
    read_byte(1'b1, d); check("r_data1", 32'(d), 32'h00);
    i2c_stop();
    clks(10);
    check("r_reg_addr_final", 32'(reg_addr), 32'hFF);
    check("r_busy_after_stop", 32'(busy), 32'h0);

    // Foreign address: no ACK, no strobes, never busy.
    watch = 1'b1;
    i2c_start();
    write_byte(8'hA2, ack); check("x_addr_nack", 32'(ack), 32'h1);
    write_byte(8'h33, ack); check("x_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    clks(10);
    watch = 1'b0;
    check("x_oe_never", 32'(oe_seen), 32'h0);
    check("x_busy_never", 32'(busy_seen), 32'h0);

    // Pointer wrap, then a byte aborted after 5 bits.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    exp_wr.push_back(16'hFF11);
    write_byte(8'h11, ack); check("wrap_d0_ack", 32'(ack), 32'h0);
    exp_wr.push_back(16'h0022);
    write_byte(8'h22, ack); check("wrap_d1_ack", 32'(ack), 32'h0);
    wa = 8'h33;
    for (int i = 7; i >= 3; i--) write_bit(wa[i]);
    i2c_stop();
    clks(10);
    check("abort_reg_addr", 32'(reg_addr), 32'h01);

    // One-cycle SCL glitches in every bit of a data byte.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    exp_wr.push_back(16'h4096);
    glitch_on = 1'b1;
    write_byte(8'h96, ack);
    glitch_on = 1'b0;
    check("glitch_ack", 32'(ack), 32'h0);
    i2c_stop();
    clks(10);

    // Reset while the address ACK is being driven.
    i2c_start();
    wa = 8'hA0;
    for (int i = 7; i >= 0; i--) write_bit(wa[i]);
    sda_m = 1'b1;
    check("ack_driven_before_reset", 32'(sda_out_en), 32'h1);
    reset = 1'b1;
    clks(1);
    check("reset_oe", 32'(sda_out_en), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_reg_addr", 32'(reg_addr), 32'h0);
    check("reset_state_idle", 32'(dut.state_q == i2c_pkg::ST_IDLE), 32'h1);
    reset = 1'b0;
    clks(10);
    i2c_stop();
    clks(10);

    // Normal write still works after the reset.
    i2c_start();
    write_byte(8'hA0, ack); check("post_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h20, ack);
    exp_wr.push_back(16'h2077);
    write_byte(8'h77, ack); check("post_d_ack", 32'(ack), 32'h0);
    i2c_stop();
    clks(20);

    check("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
